serial_uart_rx_monitor: RTL and testbench
=========================================

# serial_uart_rx_monitor

Synthesizable UART receiver that consumes the SoC's `serial_tx` line on the DE0-Nano board and buffers received bytes in a small FIFO with a valid/ready output. It is the stage directly downstream of the SoC serial port. It is used in simulation benches to capture console output and on hardware for loopback or self-check logic. Format is fixed at 8N1, LSB first, idle-high line.

## Interface
- `CLK_HZ`, 50_000_000, frequency of `clk50`.
- `BAUD`, 115200, line rate. `CLKS_PER_BIT = (CLK_HZ + BAUD/2)/BAUD` (434 at defaults); `HALF = CLKS_PER_BIT/2` (217).
- `FIFO_DEPTH`, 8, byte entries; must be a power of 2, minimum 2.

Ports:
- `clk50`  in  1  sole clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `serial_in`  in  1  asynchronous UART line (SoC `serial_tx`).
- `m_data`  out  8  FIFO head byte.
- `m_valid`  out  1  `m_data` holds an unread byte.
- `m_ready`  in  1  consumer accepts the byte; a pop occurs when `m_valid && m_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes stored.
- `frame_err`  out  1  one-cycle pulse when a bad stop bit is detected.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `clear_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Input synchronizer: two flops on `serial_in`, both reset to 1. All decisions use the second flop (`rx_s`).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A single counter `cnt` is used throughout; `bit_idx` is 3 bits.
- IDLE: when `rx_s==0`, go to START with `cnt=0`.
- START: increment `cnt`. When `cnt==HALF-1`, sample `rx_s`.
  - Sample is 1: glitch. Return to IDLE.
  - Sample is 0: go to DATA with `cnt=0` and `bit_idx=0`.
- DATA: when `cnt==CLKS_PER_BIT-1`, shift `rx_s` into `shreg[bit_idx]` (LSB first) and reset `cnt`. After `bit_idx==7`, go to STOP.
- STOP: when `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
  - Sample is 1: request a push of `shreg`, then go to IDLE.
  - Sample is 0: pulse `frame_err` for one cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
- FIFO: circular buffer with write and read pointers one bit wider than the address, and registered outputs.
  - A push is accepted if not full, or if full with a pop in the same cycle. In that case `fifo_count` is unchanged and the oldest byte leaves.
  - A push while full without a pop drops the new byte and sets `overflow`. Stored bytes are unchanged.
  - A pop while empty is ignored.
  - Pointers wrap modulo `2*FIFO_DEPTH`. Full is (addresses equal and MSBs differ); empty is (pointers equal).
- `overflow` clears only on `clear_overflow` or reset. If `clear_overflow` and a new overflow occur in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM in IDLE, `cnt=0`, pointers 0, `shreg=0`.
  - `m_data=0x00`, `m_valid=0`, `fifo_count=0`, `frame_err=0`, `overflow=0`, sync flops 1.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever pushed.
- Synchronizer latency: 2 cycles.
- The falling start edge of `serial_in`, registered at cycle 0, produces `m_valid=1` at cycle 2 + HALF + 9*CLKS_PER_BIT + 1 = 4126 at defaults. This applies when the FIFO was empty; the push is registered one cycle after the STOP sample.
- No fall-through: a byte pushed into an empty FIFO is visible on `m_data`/`m_valid` one cycle after the push.
- After a pop, the next head byte or `m_valid=0` is visible on the next cycle. Sustained 1 byte/cycle throughput with `m_ready` held high.
- `frame_err` is high for exactly the one cycle after the STOP sample.
- `fifo_count` is updated in the same cycle as the pointers.
- The block accepts back-to-back frames with a zero-length idle gap. STOP returns to IDLE at mid-stop-bit, which tolerates ±4% baud mismatch.

## Test plan
- Send 0x55 at 115200 with `m_ready=1`: `m_valid` pulses once about 4126 cycles (±2) after the start edge, with `m_data=0x55`; `frame_err` and `overflow` stay 0.
- Send 0xA3 with the stop bit forced to 0, then hold the line high: one-cycle `frame_err` pulse, `fifo_count` stays 0. A following valid 0x3C is received correctly.
- Drive a 100-cycle low glitch on an idle line: no start accepted, FSM back in IDLE, no push, no `frame_err`.
- With `m_ready=0`, send 0x01..0x09: `fifo_count=8`, `overflow=1`. Raising `m_ready` yields 0x01..0x08 in order. `clear_overflow` then drops `overflow` to 0.
- FIFO full with `m_ready=1` held as 0x0A arrives: push and pop in the same cycle, `fifo_count` stays 8, 0x0A is read last, `overflow` stays 0.
- Assert `reset_n=0` during bit 4 of 0xFF for 3 cycles, then release with the line idle: all outputs hold their reset values, nothing is pushed, and the next 0x42 is received correctly.

Source files
------------

// File: rtl/serial_uart_rx_monitor.sv
// serial_uart_rx_monitor: 8N1 UART receiver (LSB first, idle-high line)
// feeding a small byte FIFO with a valid/ready read port.
//
// Ports:
//   clk50          sole clock
//   reset_n        asynchronous active-low reset
//   serial_in      asynchronous UART line
//   m_data         FIFO head byte (registered)
//   m_valid        m_data holds an unread byte (registered)
//   m_ready        consumer accepts the head byte this cycle
//   fifo_count     number of bytes stored (registered)
//   frame_err      one-cycle pulse after a bad stop bit
//   overflow       sticky: a received byte was dropped on a full FIFO
//   clear_overflow synchronous clear of overflow (a new overflow wins)
module serial_uart_rx_monitor #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk50,
  input  logic                          reset_n,
  input  logic                          serial_in,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned PW           = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_e;

  logic             sync1_q, sync2_q;
  logic             rx_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_q, push_d;
  logic             frame_err_q, frame_err_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             overflow_q, overflow_d;
  logic             pop, full, wr_en;
  logic [AW-1:0]    waddr, raddr_next;
  logic [7:0]       head_next;

  assign rx_s = sync2_q;

  // Receive FSM: start validation at mid start bit, then one sample per bit period.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          shreg_d[bit_idx_q] = rx_s;
          cnt_d              = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Hold off on a break so a stuck-low line is not decoded as 0x00 bytes.
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO next state; head byte is pre-computed so m_data/m_valid are registered.
  always_comb begin
    pop        = m_valid_q && m_ready;
    full       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    wr_en      = push_q && (!full || pop);
    waddr      = wptr_q[AW-1:0];
    wptr_d     = wptr_q + PW'(wr_en);
    rptr_d     = rptr_q + PW'(pop);
    count_d    = wptr_d - rptr_d;
    m_valid_d  = (wptr_d != rptr_d);
    raddr_next = rptr_d[AW-1:0];
    // The byte being written this cycle may itself become the new head.
    head_next  = (wr_en && (waddr == raddr_next)) ? shreg_q : mem_q[raddr_next];
    m_data_d   = m_valid_d ? head_next : m_data_q;
    overflow_d = overflow_q;
    if (clear_overflow)              overflow_d = 1'b0;
    if (push_q && full && !pop)      overflow_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q     <= serial_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      overflow_q  <= overflow_d;
      if (wr_en) mem_q[waddr] <= shreg_q;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_uart_rx_monitor.sv
// Bench for serial_uart_rx_monitor: directed and randomized UART frames,
// checked against a queue-based byte/FIFO model and the latency formula.
module tb_serial_uart_rx_monitor;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 1_250_000;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CPB    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF   = CPB / 2;
  localparam int unsigned LAT    = 2 + HALF + 9 * CPB + 1;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic          clk50 = 1'b0;
  logic          reset_n;
  logic          serial_in;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   fifo_count;
  logic          frame_err;
  logic          overflow;
  logic          clear_overflow;

  serial_uart_rx_monitor #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk50(clk50), .reset_n(reset_n), .serial_in(serial_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk50 = ~clk50;

  // Capture every accepted byte and every cycle frame_err is high.
  logic [7:0]  got_q [$];
  int unsigned fe_cycles = 0;
  always @(posedge clk50) begin
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (frame_err) fe_cycles++;
  end

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned got_base, fe_base, model_cnt, glen;
  logic [7:0]  exp_q [$];
  logic [7:0]  b;
  logic        model_ovf, rand_done;
  int          lat, vcyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat (CPB) @(negedge clk50);
    end
  endtask

  task automatic idle(input int unsigned n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk50);
  endtask

  // Drain with m_ready high and compare everything captured since got_base to exp_q.
  task automatic drain_check(input string tag);
    m_ready = 1'b1;
    repeat (DEPTH + 4) @(negedge clk50);
    check({tag, "_count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got_q.size())
        check({tag, "_byte"}, 32'(got_q[got_base + i]), 32'(exp_q[i]));
      else
        check({tag, "_missing"}, 32'hDEAD_BEEF, 32'(exp_q[i]));
    end
    exp_q.delete();
    got_base = got_q.size();
  endtask

  initial begin
    reset_n        = 1'b0;
    serial_in      = 1'b1;
    m_ready        = 1'b0;
    clear_overflow = 1'b0;
    repeat (3) @(negedge clk50);
    check("rst_m_valid",    32'(m_valid),    32'h0);
    check("rst_m_data",     32'(m_data),     32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_overflow",   32'(overflow),   32'h0);
    reset_n = 1'b1;
    idle(5);
    got_base = got_q.size();
    fe_base  = fe_cycles;

    // 0x55 latency from the start edge, single-cycle m_valid with m_ready held.
    m_ready = 1'b1;
    lat = -1;
    vcyc = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int k = 0; k < int'(LAT) + 20; k++) begin
          @(posedge clk50);
          #1;
          if (m_valid) begin
            if (lat < 0) lat = k;
            vcyc++;
          end
        end
      end
    join
    idle(CPB);
    check("lat_0x55",   32'(lat),  32'(LAT));
    check("vcyc_0x55",  32'(vcyc), 32'd1);
    check("ovf_0x55",   32'(overflow), 32'h0);
    exp_q.push_back(8'h55);
    drain_check("rx_0x55");
    check("fe_0x55", 32'(fe_cycles - fe_base), 32'd0);

    // Bad stop bit, line held low, then a clean 0x3C.
    send_frame(8'hA3, 1'b0);
    repeat (2 * CPB) @(negedge clk50);
    idle(CPB);
    check("fe_pulse",    32'(fe_cycles - fe_base), 32'd1);
    check("fe_count",    32'(fifo_count), 32'h0);
    check("fe_no_push",  32'(got_q.size() - got_base), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    exp_q.push_back(8'h3C);
    drain_check("rx_0x3C");
    fe_base = fe_cycles;

    // Short random glitches on an idle line must be rejected.
    for (int g = 0; g < 4; g++) begin
      glen = $urandom_range(HALF - 2, 1);
      serial_in = 1'b0;
      repeat (glen) @(negedge clk50);
      idle(2 * CPB);
    end
    check("gl_count", 32'(fifo_count), 32'h0);
    check("gl_fe",    32'(fe_cycles - fe_base), 32'd0);
    check("gl_push",  32'(got_q.size() - got_base), 32'd0);
    b = 8'($urandom);
    send_frame(b, 1'b1);
    idle(CPB);
    exp_q.push_back(b);
    drain_check("rx_after_glitch");

    // Overflow: m_ready low while 0x01..0x09 arrive back to back.
    m_ready   = 1'b0;
    model_cnt = 0;
    model_ovf = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1);
      if (model_cnt < DEPTH) begin
        exp_q.push_back(8'(i));
        model_cnt++;
      end else begin
        model_ovf = 1'b1;
      end
    end
    idle(CPB);
    check("ovf_count", 32'(fifo_count), 32'(model_cnt));
    check("ovf_flag",  32'(overflow),   32'(model_ovf));
    check("ovf_head",  32'(m_data),     32'(exp_q[0]));
    m_ready = 1'b1;
    repeat (DEPTH) @(negedge clk50);
    check("thru_popped", 32'(got_q.size() - got_base), 32'(DEPTH));
    check("thru_empty",  32'(m_valid), 32'h0);
    drain_check("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'h1);
    clear_overflow = 1'b1;
    @(negedge clk50);
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Full FIFO, one-cycle pop aligned with the push of 0x0A.
    m_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      exp_q.push_back(b);
    end
    idle(CPB);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    fork
      send_frame(8'h0A, 1'b1);
      begin
        repeat (LAT) @(posedge clk50);
        @(negedge clk50);
        m_ready = 1'b1;
        @(negedge clk50);
        m_ready = 1'b0;
      end
    join
    idle(CPB);
    exp_q.push_back(8'h0A);
    check("pp_count", 32'(fifo_count), 32'(DEPTH));
    check("pp_ovf",   32'(overflow),   32'h0);
    drain_check("pp_drain");

    // Reset in the middle of bit 4 of 0xFF.
    fe_base = fe_cycles;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk50);
        reset_n = 1'b0;
        #1;
        check("mr_m_valid", 32'(m_valid),    32'h0);
        check("mr_m_data",  32'(m_data),     32'h0);
        check("mr_count",   32'(fifo_count), 32'h0);
        check("mr_ovf",     32'(overflow),   32'h0);
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;
      end
    join
    idle(2 * CPB);
    check("mr_no_push", 32'(got_q.size() - got_base), 32'd0);
    check("mr_count2",  32'(fifo_count), 32'h0);
    check("mr_fe",      32'(fe_cycles - fe_base), 32'd0);
    send_frame(8'h42, 1'b1);
    idle(CPB);
    exp_q.push_back(8'h42);
    drain_check("rx_0x42");

    // Random bytes back to back with random m_ready.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          send_frame(b, 1'b1);
        end
        idle(CPB);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          m_ready = 1'($urandom_range(1, 0));
          @(negedge clk50);
        end
      end
    join
    drain_check("rand");
    check("rand_ovf", 32'(overflow), 32'h0);
    check("rand_fe",  32'(fe_cycles - fe_base), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
